// File: rtl/seq_div_8bit_if.sv
// ----------------------------------------------------------------------------
// seq_div_8bit_if
//   Handshake and operand bundle between a controller and the iterative
//   divider seq_div_8bit.
//   Signals:
//     Start   controller -> divider  request (looked at only while idle)
//     A, B    controller -> divider  dividend / divisor
//     Busy    divider -> controller  division in progress
//     Done    divider -> controller  one-cycle result-valid pulse
//     Q, R    divider -> controller  quotient / remainder
//     DivZero divider -> controller  last accepted divisor was zero
//   Modports: master (controller side), slave (divider side).
// ----------------------------------------------------------------------------
interface seq_div_8bit_if #(
  parameter int WIDTH = 8
);
  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             DivZero;

  modport master (
    output Start, A, B,
    input  Busy, Done, Q, R, DivZero
  );

  modport slave (
    input  Start, A, B,
    output Busy, Done, Q, R, DivZero
  );
endinterface

// File: rtl/seq_div_8bit.sv
// ----------------------------------------------------------------------------
// seq_div_8bit
//   Iterative unsigned restoring divider. One quotient bit per clock; a
//   request is taken only while idle and the result is held until the next
//   result (or reset) overwrites it.
//   Ports:
//     Clk    rising-edge clock
//     Rst_n  asynchronous active-low reset; discards any partial result
//     bus    seq_div_8bit_if.slave: Start/A/B in, Busy/Done/Q/R/DivZero out
//   A zero divisor never enters RUN: the result (Q all ones, R = A,
//   DivZero = 1) is registered on the sampling edge itself.
// ----------------------------------------------------------------------------
module seq_div_8bit #(
  parameter int WIDTH = 8
) (
  input  logic          Clk,
  input  logic          Rst_n,
  seq_div_8bit_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] d_r;        // dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0] p_r;        // partial remainder
  logic [WIDTH-1:0] b_r;        // latched divisor
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] r_r;
  logic             busy_r;
  logic             done_r;
  logic             div_zero_r;

  logic             accept_s;   // Start taken with a non-zero divisor
  logic             zero_s;     // Start taken with a zero divisor
  logic             step_s;     // one restoring iteration this edge
  logic             finish_s;   // last iteration this edge

  logic [WIDTH-1:0] p_shift_s;
  logic [WIDTH:0]   diff_s;
  logic             qbit_s;
  logic [WIDTH-1:0] p_next_s;
  logic [WIDTH-1:0] d_next_s;

  // Trial subtraction one bit wider than the operands; the MSB is the borrow.
  function automatic logic [WIDTH:0] trial_sub(input logic [WIDTH-1:0] p,
                                               input logic [WIDTH-1:0] b);
    return {1'b0, p} - {1'b0, b};
  endfunction

  // FSM state register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.Start && (bus.B != '0)) begin
          state_next_s = S_RUN;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_r == CNT_LAST) begin
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_RUN;
        end
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // FSM control strobes for the datapath.
  always_comb begin
    accept_s = 1'b0;
    zero_s   = 1'b0;
    step_s   = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.Start) begin
          accept_s = (bus.B != '0);
          zero_s   = (bus.B == '0);
        end else begin
          accept_s = 1'b0;
          zero_s   = 1'b0;
        end
      end
      S_RUN: begin
        step_s   = 1'b1;
        finish_s = (cnt_r == CNT_LAST);
      end
      default: begin
        step_s   = 1'b0;
        finish_s = 1'b0;
      end
    endcase
  end

  // One restoring step: shift, trial-subtract, keep the difference on no borrow.
  // After k steps p_r < 2**k, so the bit shifted out of p_r is always zero.
  always_comb begin
    p_shift_s = {p_r[WIDTH-2:0], d_r[WIDTH-1]};
    diff_s    = trial_sub(p_shift_s, b_r);
    qbit_s    = ~diff_s[WIDTH];
    if (qbit_s) begin
      p_next_s = diff_s[WIDTH-1:0];
    end else begin
      p_next_s = p_shift_s;
    end
    d_next_s = {d_r[WIDTH-2:0], qbit_s};
  end

  // Datapath and registered outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_r      <= '0;
      d_r        <= '0;
      p_r        <= '0;
      b_r        <= '0;
      q_r        <= '0;
      r_r        <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s == S_RUN);
      done_r <= finish_s | zero_s;
      if (accept_s) begin
        d_r        <= bus.A;
        b_r        <= bus.B;
        p_r        <= '0;
        cnt_r      <= '0;
        div_zero_r <= 1'b0;
      end else if (zero_s) begin
        q_r        <= {WIDTH{1'b1}};
        r_r        <= bus.A;
        div_zero_r <= 1'b1;
      end else if (step_s) begin
        d_r   <= d_next_s;
        p_r   <= p_next_s;
        cnt_r <= cnt_r + CNT_W'(1);
        if (finish_s) begin
          q_r <= d_next_s;
          r_r <= p_next_s;
        end
      end
    end
  end

  assign bus.Busy    = busy_r;
  assign bus.Done    = done_r;
  assign bus.Q       = q_r;
  assign bus.R       = r_r;
  assign bus.DivZero = div_zero_r;

endmodule

// File: tb/tb_seq_div_8bit.sv
// ----------------------------------------------------------------------------
// tb_seq_div_8bit
//   Self-checking bench for seq_div_8bit: directed table of known quotients,
//   hand-written handshake corner cases, and random operands checked against
//   plain integer division.
// ----------------------------------------------------------------------------
module tb_seq_div_8bit;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  seq_div_8bit_if #(.WIDTH(W)) bus ();

  seq_div_8bit #(.WIDTH(W)) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Present a request at the current negedge; returns one negedge later
  // (just after the sampling edge) with Start low and operands scrambled.
  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    bus.Start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.Start = 1'b0;
    bus.A     = 8'($urandom);
    bus.B     = 8'($urandom);
  endtask

  // Counts edges after the sampling edge until Done is seen (bounded).
  task automatic wait_done(input int start_lat, output int lat,
                           output bit busy_bad, output bit seen);
    lat      = start_lat;
    busy_bad = 1'b0;
    while ((bus.Done !== 1'b1) && (lat < 40)) begin
      if (bus.Busy !== 1'b1) busy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    seen = (bus.Done === 1'b1);
    if (bus.Busy !== 1'b0) busy_bad = 1'b1;
  endtask

  // Compare the Done-cycle outputs with the arithmetic reference model.
  task automatic check_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input int lat, input bit busy_bad, input bit seen);
    logic [7:0] eq;
    logic [7:0] er;
    logic       edz;
    int         elat;
    if (b == 8'h00) begin
      eq = 8'hFF; er = a; edz = 1'b1; elat = 0;
    end else begin
      eq = a / b; er = a % b; edz = 1'b0; elat = W;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(elat));
    check({tag, "_busy"}, 32'(busy_bad), 32'd0);
    check({tag, "_q"}, 32'(bus.Q), 32'(eq));
    check({tag, "_r"}, 32'(bus.R), 32'(er));
    check({tag, "_divzero"}, 32'(bus.DivZero), 32'(edz));
    if (b != 8'h00) begin
      check({tag, "_inv_sum"}, 32'(bus.Q) * 32'(b) + 32'(bus.R), 32'(a));
      check({tag, "_inv_rlt"}, 32'(bus.R < b), 32'd1);
    end
  endtask

  initial begin
    int lat;
    bit bb;
    bit seen;
    logic [7:0] a;
    logic [7:0] b;

    vecs[0] = '{a: 8'hA5, b: 8'h5A, q: 8'h01, r: 8'h4B, dz: 1'b0};
    vecs[1] = '{a: 8'h10, b: 8'h01, q: 8'h10, r: 8'h00, dz: 1'b0};
    vecs[2] = '{a: 8'hF1, b: 8'h1F, q: 8'h07, r: 8'h18, dz: 1'b0};
    vecs[3] = '{a: 8'h13, b: 8'h31, q: 8'h00, r: 8'h13, dz: 1'b0};
    vecs[4] = '{a: 8'hFF, b: 8'hFF, q: 8'h01, r: 8'h00, dz: 1'b0};
    vecs[5] = '{a: 8'hE2, b: 8'h00, q: 8'hFF, r: 8'hE2, dz: 1'b1};
    vecs[6] = '{a: 8'h08, b: 8'h02, q: 8'h04, r: 8'h00, dz: 1'b0};

    rst_n     = 1'b0;
    bus.Start = 1'b0;
    bus.A     = 8'h00;
    bus.B     = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_done", 32'(bus.Done), 32'd0);
    check("rst_q", 32'(bus.Q), 32'd0);
    check("rst_r", 32'(bus.R), 32'd0);
    check("rst_divzero", 32'(bus.DivZero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      issue(vecs[i].a, vecs[i].b);
      wait_done(0, lat, bb, seen);
      check_op("tbl", vecs[i].a, vecs[i].b, lat, bb, seen);
      check("tbl_q_const", 32'(bus.Q), 32'(vecs[i].q));
      check("tbl_r_const", 32'(bus.R), 32'(vecs[i].r));
      check("tbl_dz_const", 32'(bus.DivZero), 32'(vecs[i].dz));
      @(negedge clk);
      check("tbl_done_width", 32'(bus.Done), 32'd0);
      check("tbl_hold_q", 32'(bus.Q), 32'(vecs[i].q));
      check("tbl_hold_dz", 32'(bus.DivZero), 32'(vecs[i].dz));
    end

    // Start while busy is ignored.
    issue(8'hA5, 8'h5A);
    @(negedge clk);
    bus.Start = 1'b1;
    bus.A     = 8'h00;
    bus.B     = 8'h01;
    @(negedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    wait_done(3, lat, bb, seen);
    check_op("ignore", 8'hA5, 8'h5A, lat, bb, seen);

    // Start in the Done cycle is accepted; old result held meanwhile.
    issue(8'hF1, 8'h1F);
    check("dcyc_hold_q", 32'(bus.Q), 32'h01);
    check("dcyc_hold_r", 32'(bus.R), 32'h4B);
    check("dcyc_busy", 32'(bus.Busy), 32'd1);
    wait_done(0, lat, bb, seen);
    check_op("dcyc", 8'hF1, 8'h1F, lat, bb, seen);
    @(negedge clk);

    // Asynchronous reset in the middle of a division.
    issue(8'hA5, 8'h5A);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.Busy), 32'd0);
    check("mid_rst_done", 32'(bus.Done), 32'd0);
    check("mid_rst_q", 32'(bus.Q), 32'd0);
    check("mid_rst_r", 32'(bus.R), 32'd0);
    check("mid_rst_divzero", 32'(bus.DivZero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(8'hF1, 8'h1F);
    wait_done(0, lat, bb, seen);
    check_op("post_rst", 8'hF1, 8'h1F, lat, bb, seen);
    @(negedge clk);

    // Random operands against integer division.
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom);
      if ((i % 4) == 0) begin
        b = 8'($urandom_range(0, 3));
      end else begin
        b = 8'($urandom_range(0, 255));
      end
      issue(a, b);
      wait_done(0, lat, bb, seen);
      check_op("rnd", a, b, lat, bb, seen);
      @(negedge clk);
      check("rnd_done_width", 32'(bus.Done), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
